// File: rtl/elm_acc_regfile.sv
// Hidden-layer register file for the ELM datapath: DEPTH signed entries with
// write, saturating accumulate, bulk clear and a valid/ready dump stream.
module elm_acc_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic              acc_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              sat_flag,
  output logic              err_addr,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              dump_done
);

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                addr_ok;
  logic                upd_req;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   acc_val;
  logic                acc_sat;
  logic                xfer;

  assign addr_ok   = ({1'b0, addr} < DEPTH_C);
  assign upd_req   = (wr_en | acc_en) && (state == IDLE);
  assign out_valid = (state == SEND);
  assign dump_busy = (state != IDLE);
  assign dump_done = (state == DONE);
  assign out_data  = mem[out_idx];
  assign xfer      = out_valid & out_ready;

  always_comb begin
    rd_data = '0;
    if (addr_ok) rd_data = mem[addr];
  end

  // Sign-extend by one bit so overflow shows up as a disagreement of the top two bits.
  always_comb begin
    sum     = {rd_data[DATA_W-1], rd_data} + {data_in[DATA_W-1], data_in};
    acc_sat = 1'b0;
    acc_val = sum[DATA_W-1:0];
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      acc_sat = 1'b1;
      acc_val = sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (dump_start) state_nxt = SEND;
      SEND:    if (xfer && out_idx == LAST_IDX) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      out_idx <= '0;
    end else begin
      case (state)
        IDLE:    if (dump_start) out_idx <= '0;
        SEND:    if (xfer && out_idx != LAST_IDX) out_idx <= out_idx + 1'b1;
        DONE:    out_idx <= '0;
        default: out_idx <= '0;
      endcase
    end
  end

  // Write takes priority over accumulate; out-of-range addresses only raise err_addr.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sat_flag <= 1'b0;
      err_addr <= 1'b0;
    end else begin
      err_addr <= upd_req && !addr_ok;
      if (upd_req && addr_ok) begin
        if (wr_en) begin
          mem[addr] <= data_in;
        end else begin
          mem[addr] <= acc_val;
          if (acc_sat) sat_flag <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_elm_acc_regfile.sv
// Self-checking bench for elm_acc_regfile: directed and random write/accumulate
// traffic against an arithmetic reference model, plus dump stream and abort checks.
module tb_elm_acc_regfile;

  localparam int DW = 32;
  localparam int DP = 10;
  localparam int AW = 4;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst, clr, wr_en, acc_en, dump_start, out_ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] rd_data, out_data;
  logic [AW-1:0] out_idx;
  logic          sat_flag, err_addr, dump_busy, out_valid, dump_done;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] model [DP];
  bit            msat;
  bit            merr;
  bit            mbusy;

  elm_acc_regfile #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .acc_en(acc_en),
    .addr(addr), .data_in(data_in), .rd_data(rd_data), .sat_flag(sat_flag),
    .err_addr(err_addr), .dump_start(dump_start), .dump_busy(dump_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .dump_done(dump_done)
  );

  always #50 clk = ~clk;

  // Every comparison funnels through here so the counters stay in one place.
  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic a, input logic [AW-1:0] ad,
                               input logic [DW-1:0] d, input logic ds, input logic rdy);
    wr_en = w; acc_en = a; addr = ad; data_in = d; dump_start = ds; out_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] expRd(input int ad);
    return (ad < DP) ? model[ad] : '0;
  endfunction

  // Reference behaviour stated as plain integer arithmetic with clamping.
  task automatic modelUpdate(input logic w, input logic a, input int ad, input logic [DW-1:0] d);
    longint s;
    merr = 0;
    if (mbusy || !(w || a)) return;
    if (ad >= DP) begin merr = 1; return; end
    if (w) begin
      model[ad] = d;
    end else begin
      s = longint'($signed(model[ad])) + longint'($signed(d));
      if (s > MAXV) begin s = MAXV; msat = 1; end
      else if (s < MINV) begin s = MINV; msat = 1; end
      model[ad] = s[DW-1:0];
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < DP; i++) model[i] = '0;
    msat = 0; merr = 0; mbusy = 0;
  endtask

  task automatic doOp(input logic w, input logic a, input int ad, input logic [DW-1:0] d);
    applyStimulus(w, a, AW'(ad), d, 1'b0, 1'b0);
    modelUpdate(w, a, ad, d);
    step();
    checkOutput("err_addr", {31'b0, err_addr}, {31'b0, merr});
    checkOutput("sat_flag", {31'b0, sat_flag}, {31'b0, msat});
    applyStimulus(1'b0, 1'b0, AW'(ad), '0, 1'b0, 1'b0);
    #1;
    checkOutput("rd_after_op", rd_data, expRd(ad));
  endtask

  task automatic checkAll(input string tag);
    for (int i = 0; i < (1 << AW); i++) begin
      addr = AW'(i);
      #1;
      checkOutput(tag, rd_data, expRd(i));
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, {31'b0, out_valid}, '0);
    checkOutput({tag, "_busy"},  {31'b0, dump_busy}, '0);
    checkOutput({tag, "_done"},  {31'b0, dump_done}, '0);
    checkOutput({tag, "_idx"},   {28'b0, out_idx},   '0);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0, 2: random ready plus writes while busy.
  task automatic runDump(input int mode, input logic w, input int ad, input logic [DW-1:0] d);
    int  n   = 0;
    int  cyc = 0;
    logic rdy;
    applyStimulus(w, 1'b0, AW'(ad), d, 1'b1, 1'b0);
    modelUpdate(w, 1'b0, ad, d);
    step();
    mbusy = 1;
    while (n < DP && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (mode == 2)
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, DP - 1)), $urandom, 1'($urandom_range(0, 1)), rdy);
      else
        applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, rdy);
      #1;
      checkOutput("dump_valid", {31'b0, out_valid}, 32'd1);
      checkOutput("dump_idx",   {28'b0, out_idx},   DW'(n));
      checkOutput("dump_data",  out_data,           model[n]);
      checkOutput("dump_busy",  {31'b0, dump_busy}, 32'd1);
      checkOutput("dump_done_early", {31'b0, dump_done}, '0);
      if (rdy) n++;
      step();
      cyc++;
    end
    if (cyc >= 200) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL dump_timeout: observed %0d words expected %0d", n, DP);
    end
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("dump_done_pulse", {31'b0, dump_done}, 32'd1);
    checkOutput("done_valid",      {31'b0, out_valid}, '0);
    checkOutput("done_busy",       {31'b0, dump_busy}, 32'd1);
    step();
    mbusy = 0;
    checkIdleOutputs("after_dump");
    checkAll("after_dump_rd");
  endtask

  // Abort a running dump at out_idx=4 with either clr or rst.
  task automatic abortDump(input bit useRst);
    int cyc = 0;
    for (int i = 0; i < DP; i++) doOp(1'b1, 1'b0, i, DW'(200 + i));
    doOp(1'b1, 1'b0, 1, 32'h7FFF_FFFF);
    doOp(1'b0, 1'b1, 1, 32'h0000_0001);
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    step();
    dump_start = 1'b0;
    while (out_idx != 4'd4 && cyc < 50) begin step(); cyc++; end
    checkOutput("abort_reach_idx4", {28'b0, out_idx}, 32'd4);
    checkOutput("abort_data_idx4",  out_data, model[4]);
    if (useRst) rst = 1'b1; else clr = 1'b1;
    step();
    rst = 1'b0; clr = 1'b0;
    modelClear();
    checkIdleOutputs(useRst ? "rst_abort" : "clr_abort");
    checkOutput("abort_sat", {31'b0, sat_flag}, '0);
    checkAll("abort_rd");
    step();
    checkOutput("abort_no_done", {31'b0, dump_done}, '0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    modelClear();
    step(); step();
    rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkIdleOutputs("reset");
    checkOutput("reset_sat", {31'b0, sat_flag}, '0);
    checkOutput("reset_err", {31'b0, err_addr}, '0);
    checkAll("reset_rd");

    $display("[TB] write and read back");
    doOp(1'b1, 1'b0, 3, 32'h0000_0010);
    checkAll("after_wr3");

    $display("[TB] saturating accumulate");
    doOp(1'b1, 1'b0, 2, 32'h7FFF_FFF0);
    doOp(1'b0, 1'b1, 2, 32'h0000_0020);
    checkOutput("pos_clamp", rd_data, 32'h7FFF_FFFF);
    doOp(1'b0, 1'b1, 2, 32'hFFFF_FFFF);
    checkOutput("after_minus1", rd_data, 32'h7FFF_FFFE);
    doOp(1'b1, 1'b0, 0, 32'h8000_0010);
    doOp(1'b0, 1'b1, 0, 32'hFFFF_FF00);
    checkOutput("neg_clamp", rd_data, 32'h8000_0000);

    $display("[TB] write priority and bad address");
    doOp(1'b1, 1'b0, 5, 32'd1);
    doOp(1'b1, 1'b1, 5, 32'd7);
    checkOutput("wr_wins", rd_data, 32'd7);
    doOp(1'b1, 1'b0, 12, 32'hDEAD_BEEF);
    step();
    checkOutput("err_one_cycle", {31'b0, err_addr}, '0);
    checkAll("after_bad_addr");

    $display("[TB] clear");
    clr = 1'b1; wr_en = 1'b1; addr = 4'd1; data_in = 32'h55;
    step();
    clr = 1'b0; wr_en = 1'b0;
    modelClear();
    checkOutput("clr_sat", {31'b0, sat_flag}, '0);
    checkAll("after_clr");

    $display("[TB] random traffic");
    for (int k = 0; k < 80; k++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 2))
        0:       d = $urandom;
        1:       d = DW'($urandom_range(0, 1000));
        default: d = 32'h7FFF_0000 ^ DW'($urandom_range(0, 65535));
      endcase
      if ($urandom_range(0, 1) == 1) d = -d;
      doOp(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0),
           int'($urandom_range(0, 13)), d);
    end
    checkAll("after_random");

    $display("[TB] dump with ready held high");
    for (int i = 0; i < DP; i++) doOp(1'b1, 1'b0, i, DW'(100 + i));
    runDump(0, 1'b0, 0, '0);

    $display("[TB] dump with stalls");
    runDump(1, 1'b0, 0, '0);

    $display("[TB] dump with writes while busy");
    runDump(2, 1'b0, 0, '0);

    $display("[TB] write coincident with dump_start");
    runDump(0, 1'b1, 7, 32'h0000_ABCD);

    $display("[TB] abort dump");
    abortDump(1'b0);
    abortDump(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
